fpadd_arbiter: RTL and testbench

- Shares one `fpadd` instance among `N` requesters.
- Round-robin arbitration picks one request at a time.
- Sequences the adder's start/done handshake, including its operand-settle cycle and its done-drain requirement.
- Returns each sum, tagged with the requester index, on a single response channel.
- Sits between the requester clients and the `fpadd` datapath. A watchdog aborts and resets a hung adder.

---
 rtl/fpadd_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/fpadd_arbiter.sv | 159 +++++++++++++++
 tb/tb_fpadd_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpadd_pkg.sv
// Shared types and constants for the fpadd request arbiter.
// Provides the controller state enum, the FP word width and the abort NaN.
package fpadd_pkg;

    localparam int FP_WIDTH = 32;

    // Quiet NaN returned when the watchdog aborts an operation.
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request after 'last'.
// Ports: req[N] requests, last = previous grant, any = some request, gnt_idx = winner.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic                 any,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IW = $clog2(N);

    logic found;

    // Scan N positions starting just after the last winner, wrapping around.
    always_comb begin
        any     = |req;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!found && req[(int'(last) + k) % N]) begin
                found   = 1'b1;
                gnt_idx = IW'((int'(last) + k) % N);
            end
        end
    end

endmodule

// File: rtl/fpadd_arbiter.sv
// Shares one fpadd among N requesters with round-robin grant and a watchdog.
// Ports: req_* request side, rsp_* tagged response, fp_* drive/observe the fpadd.
module fpadd_arbiter
    import fpadd_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req_valid,
    input  logic [32*N-1:0]      req_a,
    input  logic [32*N-1:0]      req_b,
    output logic [N-1:0]         req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [$clog2(N)-1:0] rsp_id,
    output logic [31:0]          rsp_sum,
    output logic                 rsp_err,
    output logic                 fp_start,
    output logic [31:0]          fp_a,
    output logic [31:0]          fp_b,
    output logic                 fp_reset,
    input  logic [31:0]          fp_sum,
    input  logic                 fp_done
);

    localparam int IW = $clog2(N);
    localparam int WW = $clog2(TIMEOUT);

    state_t state_q, state_d;

    logic [IW-1:0] last_q, last_d;
    logic [WW-1:0] wd_cnt_q, wd_cnt_d;
    logic [N-1:0]  req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [IW-1:0] rsp_id_q, rsp_id_d;
    logic [31:0]   rsp_sum_q, rsp_sum_d;
    logic          rsp_err_q, rsp_err_d;
    logic          fp_start_q, fp_start_d;
    logic [31:0]   fp_a_q, fp_a_d;
    logic [31:0]   fp_b_q, fp_b_d;
    logic          fp_reset_q, fp_reset_d;

    logic          any;
    logic [IW-1:0] gnt;
    logic          wd_expired;

    rr_arbiter #(
        .N (N)
    ) u_rr (
        .req     (req_valid),
        .last    (last_q),
        .any     (any),
        .gnt_idx (gnt)
    );

    assign wd_expired = (wd_cnt_q == WW'(TIMEOUT - 1));

    // State register plus all registered outputs.
    // fp_reset resets high so the adder stays in reset until the first edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= IW'(N - 1);
            wd_cnt_q    <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_err_q   <= 1'b0;
            fp_start_q  <= 1'b0;
            fp_a_q      <= '0;
            fp_b_q      <= '0;
            fp_reset_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            wd_cnt_q    <= wd_cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_err_q   <= rsp_err_d;
            fp_start_q  <= fp_start_d;
            fp_a_q      <= fp_a_d;
            fp_b_q      <= fp_b_d;
            fp_reset_q  <= fp_reset_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (any) state_d = LOAD;
            LOAD:  state_d = RUN;
            RUN: begin
                if (fp_done)         state_d = DRAIN;
                else if (wd_expired) state_d = RESP;
            end
            DRAIN: if (!fp_done) state_d = RESP;
            RESP:  if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs.
    // fp_start and rsp_valid follow the upcoming state so they are
    // valid in the same cycle the controller sits in RUN / RESP.
    always_comb begin
        last_d      = last_q;
        wd_cnt_d    = wd_cnt_q;
        req_ready_d = '0;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_err_d   = rsp_err_q;
        fp_a_d      = fp_a_q;
        fp_b_d      = fp_b_q;
        fp_start_d  = (state_d == RUN);
        rsp_valid_d = (state_d == RESP);
        fp_reset_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any) begin
                    req_ready_d[gnt] = 1'b1;
                    fp_a_d   = req_a[int'(gnt)*FP_WIDTH +: FP_WIDTH];
                    fp_b_d   = req_b[int'(gnt)*FP_WIDTH +: FP_WIDTH];
                    rsp_id_d = gnt;
                    last_d   = gnt;
                end
            end
            LOAD: wd_cnt_d = '0;
            RUN: begin
                wd_cnt_d = wd_cnt_q + 1'b1;
                if (fp_done) begin
                    rsp_sum_d = fp_sum;
                    rsp_err_d = 1'b0;
                end else if (wd_expired) begin
                    rsp_sum_d  = FP_QNAN;
                    rsp_err_d  = 1'b1;
                    fp_reset_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_err   = rsp_err_q;
    assign fp_start  = fp_start_q;
    assign fp_a      = fp_a_q;
    assign fp_b      = fp_b_q;
    assign fp_reset  = fp_reset_q;

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Directed bench for fpadd_arbiter with a behavioural fpadd stand-in.
// The stand-in finishes special operands at once and others after 4 cycles.
module tb_fpadd_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [31:0]     rsp_sum;
    logic            rsp_err;
    logic            fp_start;
    logic [31:0]     fp_a;
    logic [31:0]     fp_b;
    logic            fp_reset;
    logic [31:0]     fp_sum;
    logic            fp_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] opa [4] = '{32'h40000001, 32'h40000002,
                             32'h40000003, 32'h40000004};
    logic [31:0] opb = 32'h40100000;
    // Stand-in returns the integer sum for ordinary pairs.
    logic [31:0] expv [4] = '{32'h80100001, 32'h80100002,
                              32'h80100003, 32'h80100004};

    fpadd_arbiter #(
        .N       (N),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_err   (rsp_err),
        .fp_start  (fp_start),
        .fp_a      (fp_a),
        .fp_b      (fp_b),
        .fp_reset  (fp_reset),
        .fp_sum    (fp_sum),
        .fp_done   (fp_done)
    );

    always #5 clk = ~clk;

    // fpadd stand-in
    logic [2:0] stub_cnt   = '0;
    logic       stub_hold  = 1'b0;
    logic       stub_stuck = 1'b0;
    logic [2:0] stub_lat;

    function automatic logic is_special(input logic [31:0] x);
        return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF);
    endfunction

    function automatic logic [31:0] stub_sum(input logic [31:0] a,
                                             input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (a == 32'h0) return b;
        if (b == 32'h0) return a;
        return a + b;
    endfunction

    assign stub_lat = (is_special(fp_a) || is_special(fp_b)) ? 3'd0 : 3'd4;
    assign fp_sum   = stub_sum(fp_a, fp_b);
    assign fp_done  = !stub_stuck &&
                      ((fp_start && stub_cnt >= stub_lat) || stub_hold);

    always @(posedge clk) begin
        if (fp_reset) begin
            stub_cnt  <= '0;
            stub_hold <= 1'b0;
        end else begin
            stub_hold <= fp_start && (stub_cnt >= stub_lat) && !stub_stuck;
            if (!fp_start)            stub_cnt <= '0;
            else if (stub_cnt != 3'd7) stub_cnt <= stub_cnt + 3'd1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_grant(input int i, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_any_grant(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (|req_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rsp(output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("hs_drop", 64'(rsp_valid), 64'd0);
    endtask

    task automatic set_ops(input int i, input logic [31:0] a,
                           input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic run_req(input int i, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp,
                           input string tag);
        bit ok;
        int c;
        set_ops(i, a, b);
        req_valid[i] = 1'b1;
        wait_grant(i, ok);
        check({tag, "_grant"}, 64'(ok), 64'd1);
        req_valid[i] = 1'b0;
        wait_rsp(c, ok);
        check({tag, "_rsp"}, 64'(ok), 64'd1);
        check({tag, "_id"}, 64'(rsp_id), 64'(i));
        check({tag, "_sum"}, 64'(rsp_sum), 64'(exp));
        check({tag, "_err"}, 64'(rsp_err), 64'd0);
        handshake();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit          ok;
        int          c;
        int          bad;
        int          runc;
        int          rstc;
        logic [31:0] s;
        logic [1:0]  id;

        reset     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_ctl", 64'({req_ready, rsp_valid, rsp_id, rsp_err,
                              fp_start, fp_reset}), 64'b0000_0_00_0_0_1);
        check("rst_sum", 64'(rsp_sum), 64'd0);
        check("rst_ops", {fp_a, fp_b}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 check("rst_fprst_hold", 64'(fp_reset), 64'd1);
        @(negedge clk);
        check("rst_fprst_clr", 64'(fp_reset), 64'd0);

        // Single add, requester 0
        set_ops(0, 32'h3F800000, 32'h40000000);
        req_valid[0] = 1'b1;
        wait_grant(0, ok);
        check("add_grant", 64'(ok), 64'd1);
        check("add_onehot", 64'(req_ready), 64'b0001);
        req_valid[0] = 1'b0;
        wait_rsp(c, ok);
        check("add_rsp", 64'(ok), 64'd1);
        check("add_lat_le10", 64'((1 + c) <= 10), 64'd1);
        check("add_sum", 64'(rsp_sum), 64'h40400000);
        check("add_id", 64'(rsp_id), 64'd0);
        check("add_err", 64'(rsp_err), 64'd0);
        handshake();

        // Zero operand, requester 2
        set_ops(2, 32'h0, 32'hC1200000);
        req_valid[2] = 1'b1;
        wait_grant(2, ok);
        check("zero_grant", 64'(ok), 64'd1);
        check("zero_load", {fp_a, fp_b}, 64'h00000000_C1200000);
        check("zero_load_start", 64'(fp_start), 64'd0);
        req_valid[2] = 1'b0;
        @(negedge clk);
        check("zero_done_c2", 64'({fp_start, fp_done}), 64'b11);
        wait_rsp(c, ok);
        check("zero_rsp", 64'(ok), 64'd1);
        check("zero_sum", 64'(rsp_sum), 64'hC1200000);
        check("zero_id", 64'(rsp_id), 64'd2);
        handshake();

        // Fairness: all requesters held valid, rsp_ready held high
        do_reset();
        for (int i = 0; i < 4; i++) set_ops(i, opa[i], opb);
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            wait_any_grant(ok);
            check("fair_grant", 64'(ok), 64'd1);
            check("fair_order", 64'(req_ready), 64'(4'b0001 << (g % 4)));
            @(negedge clk);
            check("fair_pulse", 64'(req_ready), 64'd0);
            wait_rsp(c, ok);
            check("fair_rsp", 64'(ok), 64'd1);
            check("fair_id", 64'(rsp_id), 64'(g % 4));
            check("fair_sum", 64'(rsp_sum), 64'(expv[g % 4]));
            if (g == 4) req_valid = '0;
        end
        @(negedge clk);
        rsp_ready = 1'b0;

        // Backpressure: requester 1 in flight, requester 3 waiting
        set_ops(1, 32'h3F800000, 32'h40000000);
        req_valid[1] = 1'b1;
        wait_grant(1, ok);
        check("bp_grant", 64'(ok), 64'd1);
        req_valid[1] = 1'b0;
        req_valid[3] = 1'b1;
        wait_rsp(c, ok);
        check("bp_rsp", 64'(ok), 64'd1);
        s   = rsp_sum;
        id  = rsp_id;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!rsp_valid || rsp_sum !== s || rsp_id !== id ||
                req_ready !== 4'b0000) bad++;
        end
        check("bp_stable", 64'(bad), 64'd0);
        check("bp_id", 64'(id), 64'd1);
        check("bp_sum", 64'(s), 64'h40400000);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        wait_grant(3, ok);
        check("bp_next_grant", 64'(req_ready), 64'b1000);
        req_valid[3] = 1'b0;
        wait_rsp(c, ok);
        check("bp_next_sum", 64'(rsp_sum), 64'(expv[3]));
        handshake();

        // Watchdog abort with done stuck low
        stub_stuck = 1'b1;
        set_ops(0, 32'h3F800000, 32'h40000000);
        req_valid[0] = 1'b1;
        wait_grant(0, ok);
        check("wd_grant", 64'(ok), 64'd1);
        req_valid[0] = 1'b0;
        runc = 0;
        rstc = 0;
        ok   = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (fp_start) runc++;
            if (fp_reset) rstc++;
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("wd_rsp", 64'(ok), 64'd1);
        check("wd_run_cycles", 64'(runc), 64'd16);
        check("wd_err", 64'(rsp_err), 64'd1);
        check("wd_sum", 64'(rsp_sum), 64'h7FC00000);
        check("wd_fprst_at_resp", 64'(fp_reset), 64'd1);
        @(negedge clk);
        check("wd_fprst_pulse", 64'({fp_reset, rsp_valid}), 64'b01);
        check("wd_fprst_count", 64'(rstc), 64'd1);
        handshake();
        stub_stuck = 1'b0;
        run_req(1, 32'h3F800000, 32'h40000000, 32'h40400000, "wd_next");

        // Async reset while RUN
        set_ops(2, opa[2], opb);
        req_valid[2] = 1'b1;
        wait_grant(2, ok);
        check("ar_grant", 64'(ok), 64'd1);
        req_valid[2] = 1'b0;
        @(negedge clk);
        check("ar_in_run", 64'(fp_start), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("ar_ctl", 64'({req_ready, rsp_valid, rsp_id, rsp_err,
                             fp_start, fp_reset}), 64'b0000_0_00_0_0_1);
        check("ar_sum", 64'(rsp_sum), 64'd0);
        check("ar_ops", {fp_a, fp_b}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1 check("ar_fprst_hold", 64'(fp_reset), 64'd1);
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) bad++;
        end
        check("ar_no_rsp", 64'(bad), 64'd0);
        set_ops(0, opa[0], opb);
        req_valid = 4'b0101;
        wait_any_grant(ok);
        check("ar_first", 64'(req_ready), 64'b0001);
        req_valid[0] = 1'b0;
        wait_rsp(c, ok);
        check("ar_r0_id", 64'(rsp_id), 64'd0);
        check("ar_r0_sum", 64'(rsp_sum), 64'(expv[0]));
        handshake();
        wait_grant(2, ok);
        check("ar_r2_grant", 64'(ok), 64'd1);
        req_valid[2] = 1'b0;
        wait_rsp(c, ok);
        check("ar_r2_id", 64'(rsp_id), 64'd2);
        check("ar_r2_sum", 64'(rsp_sum), 64'(expv[2]));
        handshake();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
